cla_mul_arbiter: RTL and testbench
==================================

Name: cla_mul_arbiter

Overview:
Sequencer and two-way round-robin arbiter that shares one combinational CLA multiplier (cpu_wb_cla_multiplier, unsigned MULTICAND_WID x MULTIPLIER_WID -> sum-width product) between two requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The block registers operands onto the multiplier inputs and waits a programmable number of cycles so the long CLA path is a multicycle path. It then captures the product and returns it to the owning requester. It sits between execute-stage clients and the shared multiplier instance.

Parameters:
MULTICAND_WID, 32, multiplicand width
MULTIPLIER_WID, 32, multiplier width
MUL_CYCLES, 2, cycles operands are held on the multiplier before product capture; must be >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 operands valid
req0_ready  out  1  requester 0 accepted this cycle when valid&ready
req0_multicand  in  MULTICAND_WID  requester 0 multiplicand
req0_multiplier  in  MULTIPLIER_WID  requester 0 multiplier
rsp0_valid  out  1  requester 0 product valid
rsp0_ready  in  1  requester 0 takes product
rsp0_product  out  MULTICAND_WID+MULTIPLIER_WID  requester 0 product
req1_* / rsp1_*  same as requester 0, for requester 1
mul_multicand  out  MULTICAND_WID  to multiplier .multicand, registered
mul_multiplier  out  MULTIPLIER_WID  to multiplier .multiplier, registered
mul_product  in  MULTICAND_WID+MULTIPLIER_WID  from multiplier .product
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; rsp0/1_valid=0; rsp0/1_product=0; mul_multicand=0; mul_multiplier=0; owner=0; last_grant=1, so requester 0 wins the first tie; counter=0; busy=0.
- IDLE: grant is combinational.
  - Only one reqN_valid: that requester is granted.
  - Both valid: grant goes to the requester other than last_grant.
  - reqN_ready = (state==IDLE) & grant==N. It may depend on the other requester's valid.
  - With neither valid, both ready are low.
- Accept, on an edge with valid&ready:
  - operands load into mul_multicand/mul_multiplier;
  - owner <= N; counter <= MUL_CYCLES-1; state <= CALC.
- CALC:
  - mul_* held stable; no ready asserted.
  - Each edge with counter != 0 decrements the counter.
  - On the edge with counter==0: rspN_product(owner) <= mul_product; rspN_valid(owner) <= 1; state <= RESP.
- RESP:
  - rsp valid and product held stable until rsp_ready from the owner.
  - On that handshake edge: rsp valid <= 0; last_grant <= owner; state <= IDLE.
  - The product register keeps its last value after the handshake.
- Latency: accept edge E; product captured at edge E+MUL_CYCLES; rsp_valid visible in the cycle after that edge. Minimum issue interval is MUL_CYCLES+2 cycles.
- mul_* outputs keep their last operands in IDLE/RESP; they change only on accept.
- Width: product is exactly MULTICAND_WID+MULTIPLIER_WID bits, unsigned, no truncation.
- Edge cases:
  - rsp_ready from a non-owner, or outside RESP: ignored.
  - req_valid while busy: not accepted; the requester must hold its operands.
  - Reset mid-CALC or mid-RESP: operation abandoned, no response, all reset values restored.
  - MUL_CYCLES=1: CALC lasts exactly one cycle.
  - Counter width: clog2(MUL_CYCLES+1), minimum 1.

Decomposition:
- Shared package/include cla_mul_pkg:
  - state encoding IDLE/CALC/RESP (2-bit);
  - localparam PRODUCT_WID = MULTICAND_WID+MULTIPLIER_WID;
  - requester-index constants REQ0=0, REQ1=1.
- One sub-module: rr_arb2, a 2-way combinational round-robin grant.
  - Inputs: two valids, last_grant.
  - Outputs: grant_valid, grant_idx.
- The multiplier is instantiated outside this block.

Test Plan:
- Basic (bench instantiates cpu_wb_cla_multiplier, MUL_CYCLES=2): req0 0x00007FFF x 0x0000007F, rsp0_ready=1 -> accept at edge E, rsp0_valid from edge E+2, rsp0_product=0x3F7F81, rsp1_valid stays 0, busy high E..handshake.
- Tie after reset: req0 0x00008FF0 x 0x000000F0 and req1 0x0000FFFF x 0x000000FF both valid -> req0 served first with product 0x86F100, then req1 with 0xFEFF01; req1_ready low until IDLE returns.
- Backpressure: rsp0_ready low for 10 cycles -> rsp0_valid and product stable; req0_ready/req1_ready low throughout; a pending req1 is accepted only after the rsp0 handshake.
- Extremes: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE00000001; 0 x 0xFFFFFFFF -> 0.
- Reset during CALC: rst pulse one cycle after accept -> rsp valids 0, mul_* 0, busy 0 immediately (async); a new req0 after reset completes normally.
- Fairness: both requesters hold valid for 6 operations, operand = index -> grants alternate 0,1,0,1,0,1, each product correct. Also repeat the basic test with MUL_CYCLES=1 -> capture at edge E+1.

Source files
------------

// File: rtl/cla_mul_pkg.sv
// Shared types and constants for the CLA multiplier sequencer/arbiter.
// Covers the state encoding, requester indices and counter sizing.
package cla_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_MULTICAND_WID  = 32;
   localparam int DEF_MULTIPLIER_WID = 32;
   localparam int PRODUCT_WID =
      DEF_MULTICAND_WID + DEF_MULTIPLIER_WID;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   function automatic int cnt_wid(input int cycles);
      int w;
      w = $clog2(cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin grant.
// On a tie the requester other than the last one served wins.
module rr_arb2
   import cla_mul_pkg::*;
(
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_last_grant,
   output logic o_grant_valid,
   output logic o_grant_idx
);

   logic w_tie;

   assign w_tie         = i_valid0 & i_valid1;
   assign o_grant_valid = i_valid0 | i_valid1;
   assign o_grant_idx   = w_tie ? ~i_last_grant : i_valid1;

endmodule

// File: rtl/cla_mul_arbiter.sv
// Shares one external combinational CLA multiplier between two requesters.
// Operands are held MUL_CYCLES cycles so the multiplier is a multicycle path.
module cla_mul_arbiter
   import cla_mul_pkg::*;
#(
   parameter int MULTICAND_WID  = 32,
   parameter int MULTIPLIER_WID = 32,
   parameter int MUL_CYCLES     = 2
)(
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    req0_valid,
   output logic                                    req0_ready,
   input  logic [MULTICAND_WID-1:0]                req0_multicand,
   input  logic [MULTIPLIER_WID-1:0]               req0_multiplier,
   output logic                                    rsp0_valid,
   input  logic                                    rsp0_ready,
   output logic [MULTICAND_WID+MULTIPLIER_WID-1:0] rsp0_product,
   input  logic                                    req1_valid,
   output logic                                    req1_ready,
   input  logic [MULTICAND_WID-1:0]                req1_multicand,
   input  logic [MULTIPLIER_WID-1:0]               req1_multiplier,
   output logic                                    rsp1_valid,
   input  logic                                    rsp1_ready,
   output logic [MULTICAND_WID+MULTIPLIER_WID-1:0] rsp1_product,
   output logic [MULTICAND_WID-1:0]                mul_multicand,
   output logic [MULTIPLIER_WID-1:0]               mul_multiplier,
   input  logic [MULTICAND_WID+MULTIPLIER_WID-1:0] mul_product,
   output logic                                    busy
);

   localparam int PW = MULTICAND_WID + MULTIPLIER_WID;
   localparam int CW = cnt_wid(MUL_CYCLES);
   localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);

   state_t r_state;
   state_t w_state_nxt;

   logic                      r_owner;
   logic                      r_last_grant;
   logic [CW-1:0]             r_cnt;
   logic [MULTICAND_WID-1:0]  r_mul_multicand;
   logic [MULTIPLIER_WID-1:0] r_mul_multiplier;
   logic                      r_rsp0_valid;
   logic                      r_rsp1_valid;
   logic [PW-1:0]             r_rsp0_product;
   logic [PW-1:0]             r_rsp1_product;

   logic                      w_gnt_valid;
   logic                      w_gnt_idx;
   logic                      w_idle;
   logic                      w_accept;
   logic                      w_capture;
   logic                      w_rsp_hs;
   logic [MULTICAND_WID-1:0]  w_op_a;
   logic [MULTIPLIER_WID-1:0] w_op_b;

   rr_arb2 u_arb (
      .i_valid0      (req0_valid),
      .i_valid1      (req1_valid),
      .i_last_grant  (r_last_grant),
      .o_grant_valid (w_gnt_valid),
      .o_grant_idx   (w_gnt_idx)
   );

   assign w_idle = (r_state == IDLE);
   assign w_op_a = (w_gnt_idx == REQ1) ? req1_multicand  : req0_multicand;
   assign w_op_b = (w_gnt_idx == REQ1) ? req1_multiplier : req0_multiplier;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_rsp_hs    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_gnt_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = CALC;
            end
         end
         CALC: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            // Only the owner's ready completes the response.
            if ((r_owner == REQ1) ? rsp1_ready : rsp0_ready) begin
               w_rsp_hs    = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner          <= REQ0;
         r_last_grant     <= REQ1;
         r_cnt            <= '0;
         r_mul_multicand  <= '0;
         r_mul_multiplier <= '0;
      end else begin
         if (w_accept) begin
            r_mul_multicand  <= w_op_a;
            r_mul_multiplier <= w_op_b;
            r_owner          <= w_gnt_idx;
            r_cnt            <= CNT_LOAD;
         end else if ((r_state == CALC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_rsp_hs) begin
            r_last_grant <= r_owner;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp0_valid   <= 1'b0;
         r_rsp1_valid   <= 1'b0;
         r_rsp0_product <= '0;
         r_rsp1_product <= '0;
      end else begin
         if (w_capture) begin
            if (r_owner == REQ1) begin
               r_rsp1_valid   <= 1'b1;
               r_rsp1_product <= mul_product;
            end else begin
               r_rsp0_valid   <= 1'b1;
               r_rsp0_product <= mul_product;
            end
         end
         if (w_rsp_hs) begin
            if (r_owner == REQ1) begin
               r_rsp1_valid <= 1'b0;
            end else begin
               r_rsp0_valid <= 1'b0;
            end
         end
      end
   end

   assign req0_ready     = w_idle & w_gnt_valid & (w_gnt_idx == REQ0);
   assign req1_ready     = w_idle & w_gnt_valid & (w_gnt_idx == REQ1);
   assign rsp0_valid     = r_rsp0_valid;
   assign rsp1_valid     = r_rsp1_valid;
   assign rsp0_product   = r_rsp0_product;
   assign rsp1_product   = r_rsp1_product;
   assign mul_multicand  = r_mul_multicand;
   assign mul_multiplier = r_mul_multiplier;
   assign busy           = ~w_idle;

endmodule

// File: tb/tb_cla_mul_arbiter.sv
// Randomized self-checking bench for cla_mul_arbiter against a
// transaction-level arbitration/latency model.
module tb_cla_mul_arbiter;

   localparam int MC = 2;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_multicand, req0_multiplier;
   logic [31:0] req1_multicand, req1_multiplier;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready, rsp1_ready;
   logic [63:0] rsp0_product, rsp1_product;
   logic [31:0] mul_multicand, mul_multiplier;
   logic [63:0] mul_product;
   logic        busy;

   logic        b_req0_valid, b_req0_ready;
   logic        b_req1_ready;
   logic        b_rsp0_valid, b_rsp1_valid;
   logic        b_rsp0_ready;
   logic [63:0] b_rsp0_product, b_rsp1_product;
   logic [31:0] b_mul_multicand, b_mul_multiplier;
   logic [63:0] b_mul_product;
   logic        b_busy;
   logic [31:0] b_a, b_b;

   int nchk;
   int nerr;
   bit last;

   // Stand-in for the external combinational multiplier.
   assign mul_product   = 64'(mul_multicand) * 64'(mul_multiplier);
   assign b_mul_product = 64'(b_mul_multicand) * 64'(b_mul_multiplier);

   cla_mul_arbiter #(
      .MULTICAND_WID  (32),
      .MULTIPLIER_WID (32),
      .MUL_CYCLES     (MC)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req0_valid      (req0_valid),
      .req0_ready      (req0_ready),
      .req0_multicand  (req0_multicand),
      .req0_multiplier (req0_multiplier),
      .rsp0_valid      (rsp0_valid),
      .rsp0_ready      (rsp0_ready),
      .rsp0_product    (rsp0_product),
      .req1_valid      (req1_valid),
      .req1_ready      (req1_ready),
      .req1_multicand  (req1_multicand),
      .req1_multiplier (req1_multiplier),
      .rsp1_valid      (rsp1_valid),
      .rsp1_ready      (rsp1_ready),
      .rsp1_product    (rsp1_product),
      .mul_multicand   (mul_multicand),
      .mul_multiplier  (mul_multiplier),
      .mul_product     (mul_product),
      .busy            (busy)
   );

   cla_mul_arbiter #(
      .MULTICAND_WID  (32),
      .MULTIPLIER_WID (32),
      .MUL_CYCLES     (1)
   ) dut1 (
      .clk             (clk),
      .rst             (rst),
      .req0_valid      (b_req0_valid),
      .req0_ready      (b_req0_ready),
      .req0_multicand  (b_a),
      .req0_multiplier (b_b),
      .rsp0_valid      (b_rsp0_valid),
      .rsp0_ready      (b_rsp0_ready),
      .rsp0_product    (b_rsp0_product),
      .req1_valid      (1'b0),
      .req1_ready      (b_req1_ready),
      .req1_multicand  (32'd0),
      .req1_multiplier (32'd0),
      .rsp1_valid      (b_rsp1_valid),
      .rsp1_ready      (1'b0),
      .rsp1_product    (b_rsp1_product),
      .mul_multicand   (b_mul_multicand),
      .mul_multiplier  (b_mul_multiplier),
      .mul_product     (b_mul_product),
      .busy            (b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 3))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // One full operation from grant to response handshake; the
   // requester not granted keeps its request pending.
   task automatic step(input int dly);
      bit          g;
      logic [63:0] exp;
      logic [31:0] ea, eb;
      #1;
      g  = (req0_valid && req1_valid) ? ~last : bit'(req1_valid);
      ea = g ? req1_multicand  : req0_multicand;
      eb = g ? req1_multiplier : req0_multiplier;
      exp = 64'(ea) * 64'(eb);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("rdy0", 64'(req0_ready), 64'(!g));
      chk("rdy1", 64'(req1_ready), 64'(g));
      @(posedge clk); #1;
      if (g) req1_valid = 1'b0;
      else   req0_valid = 1'b0;
      chk("busy_calc", 64'(busy), 64'd1);
      chk("mul_a", 64'(mul_multicand), 64'(ea));
      chk("mul_b", 64'(mul_multiplier), 64'(eb));
      repeat (MC) begin
         chk("calc_v", 64'({rsp1_valid, rsp0_valid}), 64'd0);
         chk("calc_rdy", 64'({req1_ready, req0_ready}), 64'd0);
         @(posedge clk); #1;
      end
      chk("rsp_v", 64'({rsp1_valid, rsp0_valid}), g ? 64'd2 : 64'd1);
      chk("rsp_p", g ? rsp1_product : rsp0_product, exp);
      for (int i = 0; i < dly; i++) begin
         if (g) rsp0_ready = 1'($urandom);
         else   rsp1_ready = 1'($urandom);
         @(posedge clk); #1;
         chk("hold_v", 64'({rsp1_valid, rsp0_valid}),
             g ? 64'd2 : 64'd1);
         chk("hold_p", g ? rsp1_product : rsp0_product, exp);
         chk("hold_rdy", 64'({req1_ready, req0_ready}), 64'd0);
         chk("hold_busy", 64'(busy), 64'd1);
      end
      rsp0_ready = !g;
      rsp1_ready = g;
      @(posedge clk); #1;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      chk("hs_v", 64'({rsp1_valid, rsp0_valid}), 64'd0);
      chk("hs_busy", 64'(busy), 64'd0);
      chk("keep_p", g ? rsp1_product : rsp0_product, exp);
      last = g;
   endtask

   initial begin
      nchk = 0;
      nerr = 0;
      last = 1'b1;
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0;
      req0_multicand = 0; req0_multiplier = 0;
      req1_multicand = 0; req1_multiplier = 0;
      rsp0_ready = 0; rsp1_ready = 0;
      b_req0_valid = 0; b_rsp0_ready = 0;
      b_a = 0; b_b = 0;
      #2;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_v", 64'({rsp1_valid, rsp0_valid}), 64'd0);
      chk("rst_p0", rsp0_product, 64'd0);
      chk("rst_p1", rsp1_product, 64'd0);
      chk("rst_mul", 64'({mul_multicand, mul_multiplier}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_rdy", 64'({req1_ready, req0_ready}), 64'd0);

      // tie right after reset, then req1 with backpressure
      req0_valid = 1; req0_multicand = 32'h8FF0;
      req0_multiplier = 32'hF0;
      req1_valid = 1; req1_multicand = 32'hFFFF;
      req1_multiplier = 32'hFF;
      step(0);
      step(10);

      // basic, then req0 backpressured with req1 pending
      req0_valid = 1; req0_multicand = 32'h7FFF;
      req0_multiplier = 32'h7F;
      step(0);
      req0_valid = 1; req0_multicand = 32'hFFFF_FFFF;
      req0_multiplier = 32'hFFFF_FFFF;
      req1_valid = 1; req1_multicand = 32'd0;
      req1_multiplier = 32'hFFFF_FFFF;
      step(10);
      step(1);
      if (req0_valid) step(0);

      // reset one cycle after accept
      req0_valid = 1; req0_multicand = 32'h1234;
      req0_multiplier = 32'h5678;
      @(posedge clk); #1;
      req0_valid = 0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("mrst_v", 64'({rsp1_valid, rsp0_valid}), 64'd0);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_mul", 64'({mul_multicand, mul_multiplier}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      last = 1'b1;
      @(posedge clk); #1;
      req0_valid = 1; req0_multicand = 32'hABCD;
      req0_multiplier = 32'h9;
      step(2);

      // fairness: both requesters always pending, operand = index
      for (int i = 0; i < 6; i++) begin
         if (!req0_valid) begin
            req0_valid = 1; req0_multicand = i;
            req0_multiplier = i + 1;
         end
         if (!req1_valid) begin
            req1_valid = 1; req1_multicand = i;
            req1_multiplier = i + 2;
         end
         step(0);
      end
      req0_valid = 0; req1_valid = 0;
      step_drain();

      // random traffic
      for (int i = 0; i < 24; i++) begin
         if (!req0_valid && $urandom_range(0, 1) == 1) begin
            req0_valid = 1; req0_multicand = rnd32();
            req0_multiplier = rnd32();
         end
         if (!req1_valid && $urandom_range(0, 1) == 1) begin
            req1_valid = 1; req1_multicand = rnd32();
            req1_multiplier = rnd32();
         end
         if (!req0_valid && !req1_valid) begin
            req0_valid = 1; req0_multicand = rnd32();
            req0_multiplier = rnd32();
         end
         step($urandom_range(0, 4));
      end

      // single-cycle multiply instance
      b_req0_valid = 1; b_a = 32'h7FFF; b_b = 32'h7F;
      #1;
      chk("m1_rdy", 64'(b_req0_ready), 64'd1);
      @(posedge clk); #1;
      b_req0_valid = 0;
      chk("m1_busy", 64'(b_busy), 64'd1);
      chk("m1_v0", 64'(b_rsp0_valid), 64'd0);
      @(posedge clk); #1;
      chk("m1_v1", 64'(b_rsp0_valid), 64'd1);
      chk("m1_p", b_rsp0_product, 64'h3F7F81);
      b_rsp0_ready = 1;
      @(posedge clk); #1;
      b_rsp0_ready = 0;
      chk("m1_hs", 64'(b_rsp0_valid), 64'd0);
      chk("m1_idle", 64'(b_busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   // Leftover pending requests are cleared above, so the arbiter
   // must sit idle with no grant.
   task automatic step_drain();
      #1;
      chk("drain_rdy", 64'({req1_ready, req0_ready}), 64'd0);
      @(posedge clk); #1;
      chk("drain_busy", 64'(busy), 64'd0);
   endtask

endmodule
